// File: rtl/lock_pkg.sv
// Mode encodings shared by the lock sequencer, display mux and entry engine.
package lock_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SET      = 2'b00,
    MODE_LOCKED   = 2'b01,
    MODE_LOCKOUT  = 2'b10,
    MODE_UNLOCKED = 2'b11
  } mode_e;

endpackage

// File: rtl/sec_tick.sv
// One-second tick prescaler: counts 0..TICK_DIV-1 while enabled, pulses on terminal count.
module sec_tick #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en & ~clr & (cnt == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || (cnt == TC)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lock_mode_controller.sv
// Combination-lock mode sequencer: SET/LOCKED/LOCKOUT/UNLOCKED, fail counter, lockout countdown.
//   state    | meaning
//   SET      | waiting for a new password to be entered
//   LOCKED   | waiting for a code; wrong codes counted in fails
//   LOCKOUT  | too many wrong codes; counting down lockout_remain seconds
//   UNLOCKED | open; btn 0 -> change password, btn 1 -> relock
module lock_mode_controller
  import lock_pkg::*;
#(
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_SEC = 10,
  parameter int TICK_DIV    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  input  logic       entry_done,
  input  logic       entry_match,
  output logic [1:0] mode,
  output logic       entry_clr,
  output logic       pw_load,
  output logic [1:0] fails,
  output logic [6:0] lockout_remain
);

  localparam logic [1:0] MAXF = 2'(MAX_FAILS);
  localparam logic [6:0] LSEC = 7'(LOCKOUT_SEC);

  mode_e      state, state_nxt;
  logic [1:0] fails_nxt;
  logic [6:0] remain_nxt;
  logic       clr_nxt, load_nxt;
  logic [3:0] btn_s1, btn_s2, btn_d, press;
  logic       tick;
  logic       unused_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 4'hF;
      btn_s2 <= 4'hF;
      btn_d  <= 4'hF;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  // Buttons are active-low, so a press is a 1->0 edge of the synchronised level.
  assign press        = btn_d & ~btn_s2;
  assign unused_press = |press[3:2];

  sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == MODE_LOCKOUT),
    .clr   (state != MODE_LOCKOUT),
    .tick  (tick)
  );

  always_comb begin
    state_nxt  = state;
    fails_nxt  = fails;
    remain_nxt = lockout_remain;
    clr_nxt    = 1'b0;
    load_nxt   = 1'b0;
    case (state)
      MODE_SET: begin
        if (entry_done) begin
          state_nxt = MODE_LOCKED;
          load_nxt  = 1'b1;
          fails_nxt = 2'd0;
          clr_nxt   = 1'b1;
        end
      end
      MODE_LOCKED: begin
        if (entry_done) begin
          clr_nxt = 1'b1;
          if (entry_match) begin
            state_nxt = MODE_UNLOCKED;
            fails_nxt = 2'd0;
          end else if (fails + 2'd1 == MAXF) begin
            state_nxt  = MODE_LOCKOUT;
            fails_nxt  = MAXF;
            remain_nxt = LSEC;
          end else begin
            fails_nxt = fails + 2'd1;
          end
        end
      end
      MODE_LOCKOUT: begin
        if (tick) begin
          if (lockout_remain == 7'd1) begin
            state_nxt  = MODE_LOCKED;
            remain_nxt = 7'd0;
            fails_nxt  = 2'd0;
            clr_nxt    = 1'b1;
          end else begin
            remain_nxt = lockout_remain - 7'd1;
          end
        end
      end
      MODE_UNLOCKED: begin
        if (press[0]) begin
          state_nxt = MODE_SET;
          clr_nxt   = 1'b1;
        end else if (press[1]) begin
          state_nxt = MODE_LOCKED;
          fails_nxt = 2'd0;
          clr_nxt   = 1'b1;
        end
      end
      default: state_nxt = MODE_SET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= MODE_SET;
      fails          <= 2'd0;
      lockout_remain <= 7'd0;
      entry_clr      <= 1'b0;
      pw_load        <= 1'b0;
    end else begin
      state          <= state_nxt;
      fails          <= fails_nxt;
      lockout_remain <= remain_nxt;
      entry_clr      <= clr_nxt;
      pw_load        <= load_nxt;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_lock_mode_controller.sv
// Directed scenarios plus random stimulus against a cycle-level behavioural model of the lock sequencer.
module tb_lock_mode_controller;

  localparam int MAXF = 3;
  localparam int LSEC = 3;
  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic       entry_done = 1'b0;
  logic       entry_match = 1'b0;
  logic [1:0] mode;
  logic       entry_clr, pw_load;
  logic [1:0] fails;
  logic [6:0] lockout_remain;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int         m_mode, m_fails, m_rem, m_clr, m_load, m_lk;
  logic [3:0] h0, h1, h2;

  always #5 clk = ~clk;

  lock_mode_controller #(.MAX_FAILS(MAXF), .LOCKOUT_SEC(LSEC), .TICK_DIV(TDIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_n          (btn_n),
    .entry_done     (entry_done),
    .entry_match    (entry_match),
    .mode           (mode),
    .entry_clr      (entry_clr),
    .pw_load        (pw_load),
    .fails          (fails),
    .lockout_remain (lockout_remain)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mode", int'(mode), m_mode);
    chk("fails", int'(fails), m_fails);
    chk("lockout_remain", int'(lockout_remain), m_rem);
    chk("entry_clr", int'(entry_clr), m_clr);
    chk("pw_load", int'(pw_load), m_load);
  endtask

  task automatic model_reset();
    m_mode = 0; m_fails = 0; m_rem = 0; m_clr = 0; m_load = 0; m_lk = 0;
    h0 = 4'hF; h1 = 4'hF; h2 = 4'hF;
  endtask

  // One rising edge: mode 0=SET 1=LOCKED 2=LOCKOUT 3=UNLOCKED.
  // A press acts two edges after the edge that first samples the low level.
  task automatic model_edge(input logic ed, input logic em, input logic [3:0] bn);
    logic [3:0] pr;
    pr = ~h1 & h2;
    h2 = h1; h1 = h0; h0 = bn;
    m_clr = 0; m_load = 0;
    case (m_mode)
      0: if (ed) begin m_mode = 1; m_load = 1; m_fails = 0; m_clr = 1; end
      1: if (ed) begin
           m_clr = 1;
           if (em) begin m_mode = 3; m_fails = 0; end
           else if (m_fails + 1 == MAXF) begin m_mode = 2; m_fails = MAXF; m_rem = LSEC; m_lk = 0; end
           else m_fails = m_fails + 1;
         end
      2: begin
           m_lk++;
           if (m_lk % TDIV == 0) begin
             m_rem = LSEC - m_lk / TDIV;
             if (m_rem == 0) begin m_mode = 1; m_fails = 0; m_clr = 1; end
           end
         end
      default: begin
           if (pr[0]) begin m_mode = 0; m_clr = 1; end
           else if (pr[1]) begin m_mode = 1; m_fails = 0; m_clr = 1; end
         end
    endcase
  endtask

  task automatic step(input logic ed, input logic em, input logic [3:0] bn);
    entry_done = ed; entry_match = em; btn_n = bn;
    @(posedge clk);
    model_edge(ed, em, bn);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'hF);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    #10 rst_n = 1'b1;

    // power-up SET -> LOCKED
    step(1'b1, 1'b0, 4'hF);
    idle(2);
    // three wrong codes -> LOCKOUT, with ignored stimulus during countdown
    step(1'b1, 1'b0, 4'hF); idle(1);
    step(1'b1, 1'b0, 4'hF); idle(1);
    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b1, 4'h0);
    step(1'b1, 1'b0, 4'hC);
    idle(12);
    // two wrong then right -> UNLOCKED
    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b1, 4'hF);
    idle(2);
    // both buttons pressed -> SET
    step(1'b0, 1'b0, 4'hC);
    step(1'b0, 1'b0, 4'hC);
    step(1'b0, 1'b0, 4'hC);
    idle(3);
    // back to LOCKED, unlock, relock with btn 1
    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b1, 4'hF);
    step(1'b0, 1'b0, 4'hD);
    idle(5);
    // enter LOCKOUT then async reset between edges
    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b0, 4'hF);
    idle(5);
    btn_n = 4'hF; entry_done = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // random phase
    for (int i = 0; i < 3000; i++) begin
      logic ed, em;
      logic [3:0] bn;
      ed = ($urandom_range(0, 3) == 0);
      em = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 4; b++) bn[b] = ($urandom_range(0, 5) != 0);
      step(ed, em, bn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
